// File: rtl/alu_exec_stage.sv
// alu_exec_stage: RISC-V execute-stage ALU with a 2-entry output/skid buffer and an illegal-op counter
module alu_exec_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [XLEN-1:0]  src_a,
  input  logic [XLEN-1:0]  src_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  result,
  output logic             zero,
  output logic             illegal,
  output logic [CNT_W-1:0] ill_cnt
);
  typedef enum logic [1:0] {EMPTY = 2'b00, ONE = 2'b10, TWO = 2'b11} state_t;
  state_t          state, state_nx;
  logic [XLEN-1:0] alu_res, skid_res;
  logic            alu_ill, skid_zero, skid_ill;
  logic            acc, drn, load_out, load_skid, from_skid;
  assign out_valid = state[1];
  assign in_ready  = !state[0];
  assign acc       = in_valid & in_ready;
  assign drn       = out_valid & out_ready;
  assign alu_ill   = !(op inside {4'b0010, 4'b0110, 4'b0000, 4'b0001});
  assign alu_res   = op == 4'b0010 ? src_a + src_b :
                     op == 4'b0110 ? src_a - src_b :
                     op == 4'b0000 ? src_a & src_b :
                     op == 4'b0001 ? src_a | src_b : '0;
  // Buffer occupancy register; in_ready and out_valid are decoded straight from it
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= EMPTY;
    else state <= state_nx;
  // Occupancy transitions and which buffer entry gets written; flush overrides everything
  always_comb begin
    state_nx  = state;
    load_out  = 1'b0;
    load_skid = 1'b0;
    from_skid = 1'b0;
    if (flush) state_nx = EMPTY;
    else
      case (state)
        EMPTY: if (acc) begin state_nx = ONE; load_out = 1'b1; end
        ONE:
          if (acc && drn) load_out = 1'b1;
          else if (acc) begin state_nx = TWO; load_skid = 1'b1; end
          else if (drn) state_nx = EMPTY;
        TWO: if (drn) begin state_nx = ONE; from_skid = 1'b1; end
        default: state_nx = EMPTY;
      endcase
  end
  // Output entry: refilled from the skid on drain-from-full, else from the ALU on accept
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      result  <= '0;
      zero    <= 1'b0;
      illegal <= 1'b0;
    end else if (from_skid) begin
      result  <= skid_res;
      zero    <= skid_zero;
      illegal <= skid_ill;
    end else if (load_out) begin
      result  <= alu_res;
      zero    <= alu_res == '0;
      illegal <= alu_ill;
    end
  // Skid entry: holds the op accepted while the output entry is stalled
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      skid_res  <= '0;
      skid_zero <= 1'b0;
      skid_ill  <= 1'b0;
    end else if (load_skid) begin
      skid_res  <= alu_res;
      skid_zero <= alu_res == '0;
      skid_ill  <= alu_ill;
    end
  // Saturating count of illegal ops actually taken in (flushed accepts don't count)
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ill_cnt <= '0;
    else if (acc && !flush && alu_ill && ill_cnt != '1) ill_cnt <= ill_cnt + 1'b1;
endmodule

// File: tb/tb_alu_exec_stage.sv
// tb_alu_exec_stage: randomized + directed bench against a queue-based reference model
module tb_alu_exec_stage;
  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, out_ready;
  logic [3:0]  op;
  logic [31:0] src_a, src_b;
  logic        in_ready, out_valid, zero, illegal;
  logic [31:0] result;
  logic [7:0]  ill_cnt;
  logic        in_ready2, out_valid2, zero2, illegal2;
  logic [31:0] result2;
  logic [1:0]  ill_cnt2;
  int          checks = 0, failures = 0;

  typedef struct {logic [31:0] r; logic z; logic il;} ent_t;
  ent_t q[$];
  int   m_cnt = 0, m_cnt2 = 0;

  always #5 clk = ~clk;

  alu_exec_stage #(.XLEN(32), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .src_a(src_a), .src_b(src_b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .illegal(illegal), .ill_cnt(ill_cnt));

  alu_exec_stage #(.XLEN(32), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready2),
    .op(op), .src_a(src_a), .src_b(src_b), .out_valid(out_valid2), .out_ready(out_ready),
    .result(result2), .zero(zero2), .illegal(illegal2), .ill_cnt(ill_cnt2));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic ent_t ref_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    ent_t e;
    e.il = 1'b0;
    case (o)
      4'b0010: e.r = a + b;
      4'b0110: e.r = a - b;
      4'b0000: e.r = a & b;
      4'b0001: e.r = a | b;
      default: begin e.r = 32'd0; e.il = 1'b1; end
    endcase
    e.z = e.r == 32'd0;
    return e;
  endfunction

  task automatic check_all();
    chk("in_ready", in_ready, q.size() < 2);
    chk("out_valid", out_valid, q.size() > 0);
    chk("ill_cnt", ill_cnt, m_cnt);
    chk("ill_cnt_w2", ill_cnt2, m_cnt2);
    if (q.size() > 0) begin
      chk("result", result, q[0].r);
      chk("zero", zero, q[0].z);
      chk("illegal", illegal, q[0].il);
    end
  endtask

  task automatic step(input logic v, input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                      input logic rdy, input logic fl);
    logic acc, drn;
    ent_t e;
    in_valid = v; op = o; src_a = a; src_b = b; out_ready = rdy; flush = fl;
    acc = v && q.size() < 2;
    drn = q.size() > 0 && rdy;
    e = ref_op(o, a, b);
    @(posedge clk);
    if (fl) q.delete();
    else begin
      if (drn) void'(q.pop_front());
      if (acc) begin
        q.push_back(e);
        if (e.il) begin
          if (m_cnt < 255) m_cnt++;
          if (m_cnt2 < 3) m_cnt2++;
        end
      end
    end
    @(negedge clk);
    check_all();
  endtask

  function automatic logic [3:0] rand_op();
    case ($urandom_range(0, 4))
      0: return 4'b0010;
      1: return 4'b0110;
      2: return 4'b0000;
      3: return 4'b0001;
      default: return 4'($urandom);
    endcase
  endfunction

  function automatic logic [31:0] rand_val();
    case ($urandom_range(0, 3))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int saved;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op = 4'd0; src_a = 32'd0; src_b = 32'd0;
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_zero", zero, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_ill_cnt", ill_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 4'b0010, 32'hFFFF_FFFF, 32'd1, 1, 0);
    chk("add_wrap", result, 0);
    chk("add_zero", zero, 1);
    step(1, 4'b0110, 32'd5, 32'd7, 1, 0);
    chk("sub_neg", result, 32'hFFFF_FFFE);
    step(1, 4'b0000, 32'hF0F0, 32'h0FF0, 1, 0);
    chk("and", result, 32'h00F0);
    step(1, 4'b0001, 32'd1, 32'd2, 1, 0);
    chk("or", result, 32'd3);
    step(1, 4'b1111, 32'd9, 32'd9, 1, 0);
    chk("ill_1111", {result, zero, illegal}, {32'd0, 1'b1, 1'b1});
    step(1, 4'b0101, 32'd9, 32'd9, 1, 0);
    chk("ill_0101", {result, zero, illegal}, {32'd0, 1'b1, 1'b1});
    chk("ill_cnt_two", ill_cnt, 2);
    for (int i = 0; i < 3; i++) step(1, 4'b1000, 32'd1, 32'd1, 1, 0);
    chk("ill_cnt_sat", ill_cnt2, 3);
    chk("ill_cnt_five", ill_cnt, 5);
    step(0, 4'b0010, 32'd0, 32'd0, 1, 0);
    // backpressure: three back-to-back ops, downstream stalled
    step(1, 4'b0010, 32'd10, 32'd1, 0, 0);
    step(1, 4'b0010, 32'd20, 32'd2, 0, 0);
    chk("bp_in_ready", in_ready, 0);
    step(1, 4'b0010, 32'd30, 32'd3, 0, 0);
    chk("bp_hold", result, 32'd11);
    step(1, 4'b0010, 32'd30, 32'd3, 1, 0);
    chk("bp_second", result, 32'd22);
    step(1, 4'b0010, 32'd30, 32'd3, 1, 0);
    chk("bp_third", result, 32'd33);
    step(0, 4'b0010, 32'd0, 32'd0, 1, 0);
    // flush while full with a new illegal op offered
    step(1, 4'b0001, 32'd4, 32'd8, 0, 0);
    step(1, 4'b0110, 32'd8, 32'd4, 0, 0);
    saved = m_cnt;
    step(1, 4'b1111, 32'd0, 32'd0, 0, 1);
    chk("flush_out_valid", out_valid, 0);
    chk("flush_in_ready", in_ready, 1);
    chk("flush_ill_cnt", ill_cnt, saved);
    step(0, 4'b0010, 32'd0, 32'd0, 1, 0);
    // throughput: continuous traffic, never stalled
    for (int i = 0; i < 20; i++) begin
      step(1, rand_op(), rand_val(), rand_val(), 1, 0);
      chk("tput_valid", out_valid, 1);
    end
    // random traffic with backpressure and occasional flush
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) != 0, rand_op(), rand_val(), rand_val(),
           $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
    // async reset while full
    step(1, 4'b1110, 32'd0, 32'd0, 0, 0);
    step(1, 4'b1010, 32'd0, 32'd0, 0, 0);
    chk("pre_rst_full", in_ready, 0);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_in_ready", in_ready, 1);
    chk("arst_ill_cnt", ill_cnt, 0);
    q.delete(); m_cnt = 0; m_cnt2 = 0;
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 4'b0010, 32'd2, 32'd3, 1, 0);
    chk("post_rst_first", result, 32'd5);
    for (int i = 0; i < 50; i++)
      step($urandom_range(0, 1), rand_op(), rand_val(), rand_val(), $urandom_range(0, 1), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
